// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle around the UART frame parser: the RX FIFO pop side,
// the payload output stream, and the frame status outputs.
interface uart_frame_parser_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd_uart;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       pl_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_len;

    // Parser side: consumes FIFO bytes, produces payload and status.
    modport slave (
        input  rx_empty, rx_data, pl_ready,
        output rd_uart, pl_data, pl_valid, pl_last,
               frame_ok, frame_err, err_code, frame_len
    );

    // Environment side: owns the FIFO and the payload sink.
    modport master (
        output rx_empty, rx_data, pl_ready,
        input  rd_uart, pl_data, pl_valid, pl_last,
               frame_ok, frame_err, err_code, frame_len
    );
endinterface

// File: rtl/uart_frame_parser.sv
// UART frame parser: hunts for SOF, collects a length-prefixed payload with
// an XOR checksum into a local buffer, and replays the payload on a
// valid/ready stream only once the checksum has matched.
module uart_frame_parser #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 100000
) (
    input logic               clk,
    input logic               reset,
    uart_frame_parser_if.slave bus
);
    localparam int            AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    wr_idx_q, wr_idx_d;
    logic [7:0]    rd_idx_q, rd_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    frame_len_q, frame_len_d;

    logic          in_frame;
    logic          pop;
    logic          emit;
    logic          wr_en;

    // Payload buffer; only written while collecting, only read while emitting.
    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    rd_data_q;

    assign in_frame  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign emit      = (state_q == S_EMIT);
    // Popping stops during EMIT so the FIFO holds back the next frame.
    assign pop       = !bus.rx_empty && (in_frame || (state_q == S_IDLE));

    assign bus.rd_uart   = pop;
    assign bus.pl_valid  = emit;
    assign bus.pl_data   = emit ? rd_data_q : 8'h00;
    assign bus.pl_last   = emit && (rd_idx_q == (len_q - 8'd1));
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.frame_len = frame_len_q;

    // Next-state: frame parsing, payload replay and the inter-byte timeout.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        xor_d       = xor_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        tmo_d       = tmo_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        frame_len_d = frame_len_q;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop && (bus.rx_data == SOF)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (pop) begin
                    if ((bus.rx_data == 8'h00) || (bus.rx_data > MAX_LEN_B)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_IDLE;
                    end else begin
                        len_d    = bus.rx_data;
                        xor_d    = bus.rx_data;
                        wr_idx_d = 8'h00;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    wr_en    = 1'b1;
                    xor_d    = xor_q ^ bus.rx_data;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if (wr_idx_q == (len_q - 8'd1)) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (pop) begin
                    if (bus.rx_data == xor_q) begin
                        frame_ok_d  = 1'b1;
                        frame_len_d = len_q;
                        rd_idx_d    = 8'h00;
                        state_d     = S_EMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_EMIT: begin
                if (bus.pl_ready) begin
                    rd_idx_d = rd_idx_q + 8'd1;
                    if (rd_idx_q == (len_q - 8'd1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timeout only runs between bytes of a frame; any pop restarts it.
        if (!in_frame || pop) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = S_IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // State and status registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= 8'h00;
            xor_q       <= 8'h00;
            wr_idx_q    <= 8'h00;
            rd_idx_q    <= 8'h00;
            tmo_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            frame_len_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            xor_q       <= xor_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            frame_len_q <= frame_len_d;
        end
    end

    // Buffer write plus registered read addressed by the next read index,
    // so the output byte is ready the cycle the index moves.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx_q[AW-1:0]] <= bus.rx_data;
        end
        rd_data_q <= mem[rd_idx_d[AW-1:0]];
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames from the test
// plan followed by a randomized frame stream checked against a frame-level
// reference parser.
module tb_uart_frame_parser;
    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         MAX_LEN = 16;
    localparam int         TIMEOUT = 50;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .SOF     (SOF),
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] fifo[$];
    logic [7:0] stream[$];
    int pop_count    = 0;
    int cyc          = 0;
    int last_pop_cyc = 0;
    int n_valid      = 0;

    int         exp_ev[$];
    int         exp_len[$];
    logic [8:0] exp_pl[$];
    int         obs_ev[$];
    int         obs_len[$];
    logic [8:0] obs_pl[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RX FIFO model: pop decision sampled mid-cycle, applied just after the edge.
    initial begin
        bit do_pop;
        bus.rx_empty = 1'b1;
        bus.rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            do_pop = bus.rd_uart && reset;
            @(posedge clk);
            cyc++;
            #1;
            if (do_pop && fifo.size() > 0) begin
                void'(fifo.pop_front());
                pop_count++;
                last_pop_cyc = cyc;
            end
            bus.rx_empty = (fifo.size() == 0);
            bus.rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
        end
    end

    // Output monitor on the falling edge.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.frame_ok || bus.frame_err) begin
                    check("ok_err_exclusive", 32'(bus.frame_ok & bus.frame_err), 32'd0);
                    if (bus.frame_ok) begin
                        obs_ev.push_back(0);
                        obs_len.push_back(int'(bus.frame_len));
                    end
                    if (bus.frame_err) obs_ev.push_back(int'(bus.err_code));
                end
                if (bus.pl_valid) begin
                    n_valid++;
                    check("no_pop_in_emit", 32'(bus.rd_uart), 32'd0);
                end
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.pl_valid), 32'd1);
                    check("stall_data", 32'(bus.pl_data), 32'(prev_data));
                end
                if (bus.pl_valid && bus.pl_ready) obs_pl.push_back({bus.pl_last, bus.pl_data});
                prev_stall = bus.pl_valid && !bus.pl_ready;
                prev_data  = bus.pl_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Push n bytes, most significant byte first.
    task automatic push_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            fifo.push_back(v[i*8 +: 8]);
            stream.push_back(v[i*8 +: 8]);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        stream.push_back(b);
    endtask

    task automatic clear_all();
        stream.delete();
        exp_ev.delete();  exp_len.delete(); exp_pl.delete();
        obs_ev.delete();  obs_len.delete(); obs_pl.delete();
        n_valid = 0;
    endtask

    // Reference parser over the whole byte stream of a section.
    task automatic model_run();
        int i;
        int n;
        int len;
        logic [7:0] x;
        i = 0;
        n = stream.size();
        while (i < n) begin
            if (stream[i] != SOF) begin
                i++;
            end else begin
                i++;
                if (i >= n) break;
                len = int'(stream[i]);
                i++;
                if (len == 0 || len > MAX_LEN) begin
                    exp_ev.push_back(1);
                end else begin
                    if (i + len >= n) break;
                    x = 8'(len);
                    for (int k = 0; k < len; k++) x = x ^ stream[i + k];
                    if (stream[i + len] == x) begin
                        exp_ev.push_back(0);
                        exp_len.push_back(len);
                        for (int k = 0; k < len; k++)
                            exp_pl.push_back({(k == len - 1) ? 1'b1 : 1'b0, stream[i + k]});
                    end else begin
                        exp_ev.push_back(2);
                    end
                    i = i + len + 1;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        model_run();
        check({tag, "_ev_count"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
            check({tag, "_ev"}, obs_ev[i], exp_ev[i]);
        check({tag, "_len_count"}, obs_len.size(), exp_len.size());
        for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++)
            check({tag, "_len"}, obs_len[i], exp_len[i]);
        check({tag, "_pl_count"}, obs_pl.size(), exp_pl.size());
        for (int i = 0; i < exp_pl.size() && i < obs_pl.size(); i++)
            check({tag, "_pl"}, 32'(obs_pl[i]), 32'(exp_pl[i]));
        clear_all();
    endtask

    // Run until the FIFO is empty and nothing is being emitted.
    // mode: 0 = ready held high, 1 = random ready, 2 = toggling ready.
    task automatic drain(input int mode, input int budget);
        int quiet;
        int k;
        quiet = 0;
        k = 0;
        while (quiet < 4 && k < budget) begin
            @(posedge clk); #2;
            k++;
            if (mode == 1) bus.pl_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) bus.pl_ready = ~bus.pl_ready;
            if (fifo.size() == 0 && !bus.pl_valid) quiet++;
            else quiet = 0;
        end
        check("drain_in_budget", 32'(quiet >= 4), 32'd1);
        bus.pl_ready = 1'b1;
    endtask

    task automatic wait_flag(input bit want_err, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (want_err ? bus.frame_err : bus.frame_ok) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int p0;
        int len;
        int kind;
        logic [7:0] x;
        logic [7:0] b;

        bus.pl_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pl_valid", 32'(bus.pl_valid), 32'd0);
        check("rst_pl_data", 32'(bus.pl_data), 32'd0);
        check("rst_pl_last", 32'(bus.pl_last), 32'd0);
        check("rst_frame_ok", 32'(bus.frame_ok), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        check("rst_frame_len", 32'(bus.frame_len), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        // Good frame, ready held high: back-to-back payload after frame_ok.
        clear_all();
        p0 = pop_count;
        push_bytes(64'hA5_03_11_22_33_03, 6);
        wait_flag(1'b0, 40, seen);
        check("good_ok_seen", 32'(seen), 32'd1);
        check("good_pops", pop_count - p0, 6);
        check("good_frame_len", 32'(bus.frame_len), 32'd3);
        check("good_b0", {bus.pl_valid, bus.pl_last, bus.pl_data}, {1'b1, 1'b0, 8'h11});
        @(negedge clk);
        check("good_b1", {bus.pl_valid, bus.pl_last, bus.pl_data}, {1'b1, 1'b0, 8'h22});
        check("good_ok_pulse", 32'(bus.frame_ok), 32'd0);
        @(negedge clk);
        check("good_b2", {bus.pl_valid, bus.pl_last, bus.pl_data}, {1'b1, 1'b1, 8'h33});
        @(negedge clk);
        check("good_done", 32'(bus.pl_valid), 32'd0);
        drain(0, 50);
        compare_model("good");

        // Backpressure with a second frame waiting in the FIFO.
        bus.pl_ready = 1'b0;
        push_bytes(64'hA5_03_11_22_33_03, 6);
        push_bytes(64'hA5_01_5C_5D, 4);
        wait_flag(1'b0, 40, seen);
        check("bp_ok_seen", 32'(seen), 32'd1);
        check("bp_fifo_held", fifo.size(), 4);
        drain(2, 200);
        compare_model("bp");

        // Bad checksum, then a good frame.
        push_bytes(64'hA5_02_10_20_31, 5);
        wait_flag(1'b1, 40, seen);
        check("csum_err_seen", 32'(seen), 32'd1);
        check("csum_err_code", 32'(bus.err_code), 32'd2);
        drain(0, 50);
        check("csum_no_valid", n_valid, 0);
        compare_model("csum");
        push_bytes(64'hA5_01_5C_5D, 4);
        drain(0, 50);
        compare_model("after_csum");

        // Bad lengths, then a frame carrying SOF as payload data.
        push_bytes(64'hA5_00_A5_11, 4);
        push_bytes(64'hA5_02_A5_07_A0, 5);
        drain(0, 80);
        check("badlen_ev_n", obs_ev.size(), 3);
        if (obs_ev.size() >= 2) begin
            check("badlen_zero", obs_ev[0], 1);
            check("badlen_big", obs_ev[1], 1);
        end
        compare_model("badlen");

        // Garbage then a stalled frame: timeout measured from the last pop.
        p0 = pop_count;
        push_bytes(64'h00_FF_5A_A5_03_11, 6);
        wait_flag(1'b1, TIMEOUT + 40, seen);
        check("tmo_err_seen", 32'(seen), 32'd1);
        check("tmo_err_code", 32'(bus.err_code), 32'd3);
        check("tmo_pops", pop_count - p0, 6);
        check("tmo_cycles", cyc - last_pop_cyc, TIMEOUT);
        drain(0, 20);
        check("tmo_no_ok", obs_ev.size(), 1);
        clear_all();

        // Reset while a frame is being emitted and stalled.
        bus.pl_ready = 1'b0;
        push_bytes(64'hA5_03_11_22_33_03, 6);
        wait_flag(1'b0, 40, seen);
        check("rmid_ok_seen", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rmid_valid", 32'(bus.pl_valid), 32'd0);
        check("rmid_data", 32'(bus.pl_data), 32'd0);
        check("rmid_len", 32'(bus.frame_len), 32'd0);
        @(negedge clk);
        check("rmid_err_code", 32'(bus.err_code), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        bus.pl_ready = 1'b1;
        clear_all();
        push_bytes(64'hA5_02_44_55_13, 5);
        drain(0, 50);
        compare_model("after_reset");

        // Randomized frame stream with random backpressure.
        for (int f = 0; f < 30; f++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                b = 8'($urandom_range(0, 255));
                if (b == SOF) b = 8'h00;
                push_byte(b);
            end
            push_byte(SOF);
            kind = (f < 2) ? 5 : int'($urandom_range(0, 5));
            if (kind == 0) begin
                push_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = (f == 0) ? MAX_LEN : (f == 1) ? 1 : int'($urandom_range(1, MAX_LEN));
                push_byte(8'(len));
                x = 8'(len);
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    x = x ^ b;
                    push_byte(b);
                end
                if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
                push_byte(x);
            end
        end
        drain(1, 20000);
        compare_model("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
